// File: rtl/weight_fetch_arbiter.sv
// weight_fetch_arbiter: shares the single weight_store read port among N_REQ requesters.
// Each requester posts one burst (tensor, base address, length in bytes). Grants are
// round-robin. An accepted burst walks ws_addr one byte per cycle, and a tag pipe
// RD_LAT deep marks each returning beat with its owner and its last flag.
// Bursts that fall outside the fixed 36-tensor depth map are rejected with an err pulse.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid / req_ready    per-requester burst handshake (req_ready combinational, one-hot)
//   req_tensor/addr/len      packed request fields, requester i at [i*W +: W]
//   ws_tensor_sel, ws_addr   registered weight_store read address
//   ws_data, ws_scale        weight_store read data (RD_LAT edges after address change)
//   rd_valid/id/last         tagged read stream (pipe tail); rd_data/rd_scale pass through
//   err, err_id              one-cycle reject pulse; err_id held until the next reject
//   busy                     arbiter is not idle
module weight_fetch_arbiter #(
  parameter int unsigned N_REQ  = 3,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned TS_W   = 6,
  parameter int unsigned ADDR_W = 16,
  localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*TS_W-1:0]   req_tensor,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*17-1:0]     req_len,
  output logic [TS_W-1:0]         ws_tensor_sel,
  output logic [ADDR_W-1:0]       ws_addr,
  input  logic [7:0]              ws_data,
  input  logic [31:0]             ws_scale,
  output logic                    rd_valid,
  output logic [7:0]              rd_data,
  output logic [31:0]             rd_scale,
  output logic [ID_W-1:0]         rd_id,
  output logic                    rd_last,
  output logic                    err,
  output logic [ID_W-1:0]         err_id,
  output logic                    busy
);

  localparam int unsigned LEN_W     = 17;
  localparam int unsigned SUM_W     = LEN_W + 1;
  localparam int unsigned N_TENSOR  = 36;
  localparam int unsigned DCNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ERR, S_ISSUE, S_DRAIN} state_t;

  state_t              state, state_nxt;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     id_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    cnt;
  logic [DCNT_W-1:0]   dcnt;

  logic [N_REQ-1:0]    grant;
  logic [ID_W-1:0]     gid;
  logic                found;
  logic [TS_W-1:0]     sel_tensor;
  logic [ADDR_W-1:0]   sel_addr;
  logic [LEN_W-1:0]    sel_len;
  logic                reject;
  logic                is_last;

  logic [RD_LAT-1:0]   pv;
  logic [RD_LAT-1:0]   pl;
  logic [ID_W-1:0]     pid [RD_LAT];

  // Byte depth of each tensor; tensors 2..33 repeat an 8-entry layer pattern.
  function automatic logic [LEN_W-1:0] depth_of(input logic [TS_W-1:0] sel);
    logic [TS_W-1:0] off;
    off = sel - TS_W'(2);
    if (sel < TS_W'(2))   return LEN_W'(32768);
    if (sel >= TS_W'(34)) return LEN_W'(128);
    case (off[2:0])
      3'd2:       return LEN_W'(49152);
      3'd3:       return LEN_W'(16384);
      3'd6, 3'd7: return LEN_W'(65536);
      default:    return LEN_W'(128);
    endcase
  endfunction

  // Round-robin scan starting one past the last grant, plus field mux of the winner.
  always_comb begin
    grant      = '0;
    gid        = '0;
    found      = 1'b0;
    sel_tensor = '0;
    sel_addr   = '0;
    sel_len    = '0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      for (int i = 0; i < int'(N_REQ); i++) begin
        if (!found && req_valid[i] && (i == (int'(rr_ptr) + k) % int'(N_REQ))) begin
          found    = 1'b1;
          gid      = ID_W'(i);
          grant[i] = 1'b1;
        end
      end
    end
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (grant[i]) begin
        sel_tensor = req_tensor[i*TS_W +: TS_W];
        sel_addr   = req_addr[i*ADDR_W +: ADDR_W];
        sel_len    = req_len[i*LEN_W +: LEN_W];
      end
    end
  end

  // One guard bit on the end-address sum so illegal lengths cannot wrap back into range.
  assign reject = (sel_len == '0) ||
                  (sel_tensor >= TS_W'(N_TENSOR)) ||
                  ((SUM_W'(sel_addr) + SUM_W'(sel_len)) > SUM_W'(depth_of(sel_tensor)));

  assign is_last = (cnt == len_q - LEN_W'(1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state and combinational handshake/busy.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        busy      = 1'b0;
        req_ready = grant;
        if (found) state_nxt = reject ? S_ERR : S_ISSUE;
      end
      S_ERR:   state_nxt = S_IDLE;
      S_ISSUE: if (is_last) state_nxt = S_DRAIN;
      S_DRAIN: if (dcnt == DCNT_W'(RD_LAT - 1)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Burst datapath: latch on handshake, walk the address during ISSUE, count DRAIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ws_tensor_sel <= '0;
      ws_addr       <= '0;
      cnt           <= '0;
      dcnt          <= '0;
      rr_ptr        <= ID_W'(N_REQ - 1);
      id_q          <= '0;
      len_q         <= '0;
      err           <= 1'b0;
      err_id        <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (found) begin
            rr_ptr <= gid;
            id_q   <= gid;
            len_q  <= sel_len;
            if (reject) begin
              err    <= 1'b1;
              err_id <= gid;
            end else begin
              ws_tensor_sel <= sel_tensor;
              ws_addr       <= sel_addr;
              cnt           <= '0;
            end
          end
        end
        S_ISSUE: begin
          if (is_last) begin
            dcnt <= '0;
          end else begin
            ws_addr <= ws_addr + ADDR_W'(1);
            cnt     <= cnt + LEN_W'(1);
          end
        end
        S_DRAIN: dcnt <= dcnt + DCNT_W'(1);
        default: ;
      endcase
    end
  end

  // Tag pipe aligned with the weight_store read latency; empty tags outside ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
      pl <= '0;
      for (int i = 0; i < int'(RD_LAT); i++) pid[i] <= '0;
    end else begin
      for (int i = int'(RD_LAT) - 1; i > 0; i--) begin
        pv[i]  <= pv[i-1];
        pl[i]  <= pl[i-1];
        pid[i] <= pid[i-1];
      end
      pv[0]  <= (state == S_ISSUE);
      pl[0]  <= (state == S_ISSUE) && is_last;
      pid[0] <= (state == S_ISSUE) ? id_q : '0;
    end
  end

  assign rd_valid = pv[RD_LAT-1];
  assign rd_last  = pl[RD_LAT-1];
  assign rd_id    = pid[RD_LAT-1];
  assign rd_data  = ws_data;
  assign rd_scale = ws_scale;

endmodule
